// File: rtl/hc595_rx_pkg.sv
// Shared constants and select-byte decode for the 74HC595 frame receiver.
package hc595_rx_pkg;
  localparam int FRAME_BITS = 16;
  localparam int SEL_MSB    = 15;
  localparam int SEL_LSB    = 8;
  localparam int SEG_MSB    = 7;
  localparam int BITCNT_W   = 5;

  // Returns {ok, idx}: ok when exactly one bit of sel is zero.
  function automatic logic [3:0] onecold_idx(input logic [7:0] sel);
    int zeros;
    logic [2:0] idx;
    zeros = 0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!sel[i]) begin
        zeros++;
        idx = 3'(i);
      end
    end
    return {(zeros == 1), idx};
  endfunction
endpackage

// File: rtl/hc595_frame_receiver_sync.sv
// Pin synchronizer with a one-clk rising-edge pulse on the synchronized level.
module pin_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
endmodule

// File: rtl/hc595_frame_receiver.sv
// 74HC595-chain emulator: shifts 16-bit frames, latches on rclk, fills display buffer.
// Optional HC595_RX_CASCADE_EN adds ser_out (QH') for daisy-chaining.
module hc595_frame_receiver
  import hc595_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_in,
  input  logic        ser_in,
  input  logic        rclk_in,
  input  logic        srclr_n_in,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [2:0]  digit_idx,
  output logic        sel_err,
  output logic        short_err,
  output logic        overrun,
  input  logic        clr_flags,
  input  logic [2:0]  rd_addr,
`ifdef HC595_RX_CASCADE_EN
  output logic        ser_out,
`endif
  output logic [7:0]  rd_seg
);
  logic sclk_rise, rclk_rise, ser_lvl, srclr_lvl;
  logic sclk_lvl_unused, rclk_lvl_unused;
  logic ser_rise_unused, srclr_rise_unused;

  logic [FRAME_BITS-1:0] sr;
  logic [BITCNT_W-1:0]   bit_cnt;
  logic [7:0]            disp [DIGITS];
  logic [3:0]            dec;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk_in),
    .level(sclk_lvl_unused), .rise(sclk_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ser (
    .clk(clk), .rst_n(rst_n), .din(ser_in),
    .level(ser_lvl), .rise(ser_rise_unused));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rclk (
    .clk(clk), .rst_n(rst_n), .din(rclk_in),
    .level(rclk_lvl_unused), .rise(rclk_rise));
  // Clear input idles high so reset does not look like a clear edge.
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_srclr (
    .clk(clk), .rst_n(rst_n), .din(srclr_n_in),
    .level(srclr_lvl), .rise(srclr_rise_unused));

  assign dec = onecold_idx(sr[SEL_MSB:SEL_LSB]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr          <= '0;
      bit_cnt     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      digit_idx   <= '0;
      sel_err     <= 1'b0;
      short_err   <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= '0;
    end else begin
      if (clr_flags) begin
        short_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (!srclr_lvl) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        sr <= {sr[FRAME_BITS-2:0], ser_lvl};
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
      end
      // Latch sees the pre-shift register; its count restart wins.
      if (rclk_rise) begin
        frame_data  <= sr;
        frame_valid <= 1'b1;
        bit_cnt     <= (srclr_lvl && sclk_rise) ? BITCNT_W'(1) : '0;
        if (bit_cnt < BITCNT_W'(FRAME_BITS)) short_err <= 1'b1;
        if (frame_valid && !frame_ready) overrun <= 1'b1;
        if (dec[3]) begin
          digit_idx    <= dec[2:0];
          sel_err      <= 1'b0;
          disp[dec[2:0]] <= sr[SEG_MSB:0];
        end else begin
          sel_err <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  assign rd_seg = disp[rd_addr];
`ifdef HC595_RX_CASCADE_EN
  assign ser_out = sr[FRAME_BITS-1];
`endif
endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Scoreboard bench for hc595_frame_receiver: pin-level frames in, latched frames out.
module tb_hc595_frame_receiver;
  localparam int SYNC = 2;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        sclk_in = 0, ser_in = 0, rclk_in = 0, srclr_n_in = 1;
  logic [15:0] frame_data;
  logic        frame_valid, frame_ready = 0;
  logic [2:0]  digit_idx;
  logic        sel_err, short_err, overrun;
  logic        clr_flags = 0;
  logic [2:0]  rd_addr = 0;
  logic [7:0]  rd_seg;
`ifdef HC595_RX_CASCADE_EN
  logic        ser_out;
`endif

  hc595_frame_receiver #(.SYNC_STAGES(SYNC), .DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_in(sclk_in), .ser_in(ser_in),
    .rclk_in(rclk_in), .srclr_n_in(srclr_n_in),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .digit_idx(digit_idx),
    .sel_err(sel_err), .short_err(short_err), .overrun(overrun),
    .clr_flags(clr_flags), .rd_addr(rd_addr),
`ifdef HC595_RX_CASCADE_EN
    .ser_out(ser_out),
`endif
    .rd_seg(rd_seg));

  always #5 clk = ~clk;

  logic [15:0] m_sr;
  int          m_cnt;
  logic [7:0]  m_buf [8];
  logic [2:0]  m_idx;
  logic        m_sel_err, m_short, m_over, m_valid;
  logic [15:0] exp_q [$];
  int          pass = 0, total = 0;

  task automatic model_reset();
    m_sr = 0; m_cnt = 0; m_idx = 0;
    m_sel_err = 0; m_short = 0; m_over = 0; m_valid = 0;
    for (int i = 0; i < 8; i++) m_buf[i] = 0;
    exp_q.delete();
  endtask

  task automatic check_buf(input string name);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      total++;
      if (rd_seg !== m_buf[a])
        $display("FAIL %s buf[%0d] got %h exp %h", name, a, rd_seg, m_buf[a]);
      else pass++;
    end
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); ser_in = v[i];
      repeat (2) @(negedge clk); sclk_in = 1;
      repeat (3) @(negedge clk); sclk_in = 0;
      repeat (2) @(negedge clk);
      m_sr = {m_sr[14:0], v[i]};
      if (m_cnt < 31) m_cnt++;
    end
  endtask

  task automatic do_latch(input string name);
    int zeros, n;
    logic [2:0] pos;
    logic was_valid;
    was_valid = m_valid;
    if (m_valid) begin
      void'(exp_q.pop_back());
      m_over = 1;
    end
    exp_q.push_back(m_sr);
    if (m_cnt < 16) m_short = 1;
    m_cnt = 0;
    zeros = 0; pos = 0;
    for (int i = 0; i < 8; i++)
      if (m_sr[8+i] == 1'b0) begin zeros++; pos = 3'(i); end
    if (zeros == 1) begin
      m_idx = pos; m_sel_err = 0; m_buf[pos] = m_sr[7:0];
    end else m_sel_err = 1;
    m_valid = 1;
    @(negedge clk); rclk_in = 1;
    n = 0;
    if (!was_valid) begin
      do begin @(negedge clk); n++; end
      while (frame_valid !== 1'b1 && n < 20);
      total++;
      if (n != SYNC + 1)
        $display("FAIL %s latency got %0d exp %0d", name, n, SYNC + 1);
      else pass++;
    end else repeat (4) @(negedge clk);
    rclk_in = 0;
    repeat (3) @(negedge clk);
    total++;
    if (digit_idx !== m_idx)
      $display("FAIL %s digit_idx got %0d exp %0d", name, digit_idx, m_idx);
    else pass++;
    total++;
    if (sel_err !== m_sel_err)
      $display("FAIL %s sel_err got %b exp %b", name, sel_err, m_sel_err);
    else pass++;
    total++;
    if (short_err !== m_short)
      $display("FAIL %s short_err got %b exp %b", name, short_err, m_short);
    else pass++;
    total++;
    if (overrun !== m_over)
      $display("FAIL %s overrun got %b exp %b", name, overrun, m_over);
    else pass++;
`ifdef HC595_RX_CASCADE_EN
    total++;
    if (ser_out !== m_sr[15])
      $display("FAIL %s ser_out got %b exp %b", name, ser_out, m_sr[15]);
    else pass++;
`endif
  endtask

  task automatic consume(input string name);
    logic [15:0] e;
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b1)
      $display("FAIL %s valid_before got %b exp 1", name, frame_valid);
    else pass++;
    total++;
    if (exp_q.size() == 0)
      $display("FAIL %s scoreboard empty got frame %h exp none", name, frame_data);
    else begin
      e = exp_q.pop_front();
      if (frame_data !== e)
        $display("FAIL %s frame_data got %h exp %h", name, frame_data, e);
      else pass++;
    end
    frame_ready = 1;
    @(negedge clk);
    frame_ready = 0;
    m_valid = 0;
    total++;
    if (frame_valid !== 1'b0)
      $display("FAIL %s valid_after got %b exp 0", name, frame_valid);
    else pass++;
  endtask

  task automatic pulse_clr(input string name);
    @(negedge clk); clr_flags = 1;
    @(negedge clk); clr_flags = 0;
    m_short = 0; m_over = 0;
    total++;
    if (short_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL %s flags got %b%b exp 00", name, short_err, overrun);
    else pass++;
  endtask

  task automatic test_reset(input string name);
    @(negedge clk); rst_n = 0;
    repeat (3) @(negedge clk); rst_n = 1;
    model_reset();
    @(negedge clk);
    total++;
    if ({frame_data, frame_valid, digit_idx, sel_err, short_err, overrun} !== 23'd0)
      $display("FAIL %s outputs got %h/%b/%0d/%b%b%b exp all 0", name,
               frame_data, frame_valid, digit_idx, sel_err, short_err, overrun);
    else pass++;
    check_buf(name);
  endtask

  task automatic test_basic();
    shift_bits(16'hFB5A, 16);
    do_latch("basic");
    check_buf("basic");
    consume("basic");
  endtask

  task automatic test_sel_err();
    shift_bits(16'hF311, 16);
    do_latch("sel_err");
    check_buf("sel_err");
    consume("sel_err");
  endtask

  task automatic test_short();
    shift_bits(16'h02A5, 10);
    do_latch("short");
    pulse_clr("short_clr");
    consume("short");
  endtask

  task automatic test_overrun();
    shift_bits(16'hFE01, 16);
    do_latch("ovr1");
    shift_bits(16'hFD02, 16);
    do_latch("ovr2");
    check_buf("ovr");
    consume("ovr");
    pulse_clr("ovr_clr");
  endtask

  task automatic test_srclr();
    shift_bits(16'h00C3, 8);
    @(negedge clk); srclr_n_in = 0;
    repeat (4) @(negedge clk); srclr_n_in = 1;
    repeat (4) @(negedge clk);
    m_sr = 0; m_cnt = 0;
    shift_bits(16'h7FFF, 16);
    do_latch("srclr");
    consume("srclr");
  endtask

  task automatic test_reset_mid();
    shift_bits(16'h0155, 9);
    test_reset("reset_mid");
    shift_bits(16'hEF33, 16);
    do_latch("after_reset");
    check_buf("after_reset");
    consume("after_reset");
  endtask

  initial begin
    model_reset();
    test_reset("reset");
    test_basic();
    test_sel_err();
    test_short();
    test_overrun();
    test_srclr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
